// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: IR/CON handshake and datapath strobes between the sequencer and the mini-SRC datapath
interface branch_sequencer_if;
    logic        start;
    logic [31:0] ir;
    logic        con;
    logic        con_in;
    logic [1:0]  con_bits;
    logic        gra;
    logic        r_out;
    logic        pc_out;
    logic        y_in;
    logic        c_out;
    logic        alu_add;
    logic        z_in;
    logic        zlow_out;
    logic        pc_in;
    logic        taken;
    logic        busy;
    logic        done;
    logic        err;
    modport master (
        output start, ir, con,
        input  con_in, con_bits, gra, r_out, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in, taken, busy, done, err
    );
    modport slave (
        input  start, ir, con,
        output con_in, con_bits, gra, r_out, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in, taken, busy, done, err
    );
endinterface

// File: rtl/branch_sequencer.sv
// branch_sequencer: runs the T3-T6 steps of brzr/brnz/brpl/brmi, loading PC only when the CON flip-flop is set
module branch_sequencer #(
    parameter int                 OPC_W      = 5,
    parameter logic [OPC_W-1:0]   OPC_BRANCH = 5'b10010
) (
    input logic clk,
    input logic reset,
    branch_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_RA, S_PC, S_ADD, S_LOAD, S_DONE} state_t;
    state_t     state, state_nxt;
    logic [1:0] c2_q;
    logic       taken_q;
    logic       err_q;
    logic       is_branch;
    logic       accept;
    logic       unused_ir;
    assign is_branch = bus.ir[31:32-OPC_W] == OPC_BRANCH;
    assign accept    = state == S_IDLE && bus.start;
    assign unused_ir = ^{bus.ir[26:21], bus.ir[18:0]};
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            c2_q    <= 2'b00;
            taken_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= accept && !is_branch;
            if (accept && is_branch) begin
                c2_q    <= bus.ir[20:19];
                taken_q <= 1'b0;
            end
            if (state == S_LOAD) taken_q <= bus.con;
        end
    end
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = (accept && is_branch) ? S_RA : S_IDLE;
            S_RA:    state_nxt = S_PC;
            S_PC:    state_nxt = S_ADD;
            S_ADD:   state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end
    // CON has latched the Ra test by S_LOAD, so it gates the PC load directly
    assign bus.con_in   = state == S_RA;
    assign bus.con_bits = c2_q;
    assign bus.gra      = state == S_RA;
    assign bus.r_out    = state == S_RA;
    assign bus.pc_out   = state == S_PC;
    assign bus.y_in     = state == S_PC;
    assign bus.c_out    = state == S_ADD;
    assign bus.alu_add  = state == S_ADD;
    assign bus.z_in     = state == S_ADD;
    assign bus.zlow_out = state == S_LOAD;
    assign bus.pc_in    = state == S_LOAD && bus.con;
    assign bus.taken    = (state == S_LOAD) ? bus.con : taken_q;
    assign bus.busy     = state != S_IDLE;
    assign bus.done     = state == S_DONE;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: scoreboard bench comparing every output each cycle against a per-step model
module tb_branch_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    branch_sequencer_if bus();
    branch_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
    int checks = 0;
    int passed = 0;
    logic [15:0] sbq[$];
    logic [1:0]  lat_c2;
    logic        lat_taken;
    function automatic logic [15:0] obs();
        return {bus.con_in, bus.con_bits, bus.gra, bus.r_out, bus.pc_out, bus.y_in, bus.c_out,
                bus.alu_add, bus.z_in, bus.zlow_out, bus.pc_in, bus.taken, bus.busy, bus.done, bus.err};
    endfunction
    // k = cycle after the accepting edge (1=S_RA .. 5=S_DONE), 0 = idle
    function automatic logic [15:0] mk(int k, logic [1:0] c2, logic tk, logic cn, logic er);
        return {k == 1, c2, k == 1, k == 1, k == 2, k == 2, k == 3, k == 3, k == 3, k == 4,
                k == 4 && cn, tk, k >= 1, k == 5, er};
    endfunction
    task automatic run_seq(input string name, input logic [31:0] irv, input logic cv,
                           input int mid_k, input logic [31:0] mid_ir);
        logic [1:0]  c2;
        logic [15:0] e, o;
        c2 = irv[20:19];
        bus.ir = irv;
        bus.start = 1'b1;
        bus.con = ~cv;
        for (int k = 1; k <= 5; k++) sbq.push_back(mk(k, c2, (k >= 4) ? cv : 1'b0, cv, 1'b0));
        sbq.push_back(mk(0, c2, cv, cv, 1'b0));
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            bus.start = (k == mid_k);
            if (mid_k > 0 && k >= 2) bus.ir = mid_ir;
            bus.con = (k == 4) ? cv : ~cv;
            #1;
            e = sbq.pop_front();
            o = obs();
            checks++;
            if (o !== e) $display("FAIL %s cycle %0d: got %b expected %b", name, k, o, e);
            else passed++;
        end
        bus.start = 1'b0;
        lat_c2 = c2;
        lat_taken = cv;
    endtask
    task automatic test_reset();
        logic [15:0] o;
        reset = 1'b1;
        bus.start = 1'b1;
        bus.ir = 32'h9000_0023;
        bus.con = 1'b1;
        for (int k = 0; k < 5; k++) sbq.push_back(16'h0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin
                reset = 1'b0;
                bus.start = 1'b0;
            end
            #1;
            o = obs();
            checks++;
            if (o !== sbq.pop_front()) $display("FAIL reset cycle %0d: got %b expected 0", k, o);
            else passed++;
        end
        lat_c2 = 2'b00;
        lat_taken = 1'b0;
    endtask
    task automatic test_brzr_taken();
        run_seq("brzr_taken", 32'h9000_0023, 1'b1, 0, 32'h0);
    endtask
    task automatic test_brmi_not_taken();
        run_seq("brmi_not_taken_start_in_done", 32'h9018_0023, 1'b0, 5, 32'h9018_0023);
    endtask
    task automatic test_err();
        logic [15:0] e, o;
        bus.ir = 32'h1800_0000;
        bus.start = 1'b1;
        sbq.push_back(mk(0, lat_c2, lat_taken, 1'b0, 1'b1));
        sbq.push_back(mk(0, lat_c2, lat_taken, 1'b0, 1'b0));
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            #1;
            e = sbq.pop_front();
            o = obs();
            checks++;
            if (o !== e) $display("FAIL err cycle %0d: got %b expected %b", k, o, e);
            else passed++;
        end
    endtask
    task automatic test_back_to_back();
        run_seq("start_during_add", 32'h9018_0023, 1'b1, 3, 32'h9008_0023);
    endtask
    task automatic test_reset_mid();
        logic [15:0] e, o;
        bus.ir = 32'h9000_0023;
        bus.start = 1'b1;
        bus.con = 1'b0;
        sbq.push_back(mk(1, 2'b00, 1'b0, 1'b0, 1'b0));
        sbq.push_back(mk(2, 2'b00, 1'b0, 1'b0, 1'b0));
        sbq.push_back(16'h0);
        sbq.push_back(16'h0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            reset = (k == 2);
            #1;
            e = sbq.pop_front();
            o = obs();
            checks++;
            if (o !== e) $display("FAIL reset_mid cycle %0d: got %b expected %b", k, o, e);
            else passed++;
        end
        lat_c2 = 2'b00;
        lat_taken = 1'b0;
        run_seq("restart_after_reset", 32'h9000_0023, 1'b1, 0, 32'h0);
    endtask
    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.ir = 32'h0;
        bus.con = 1'b0;
        lat_c2 = 2'b00;
        lat_taken = 1'b0;
        test_reset();
        test_brzr_taken();
        test_brmi_not_taken();
        test_err();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Control-side sequencer for conditional branch instructions (brzr/brnz/brpl/brmi) in the mini-SRC datapath.
- Drives the CON flip-flop interface: asserts CONin and supplies the condition bits while Ra is on the bus. Later reads the latched CON result to decide whether the computed target is loaded into PC.
- Sits between the IR and the datapath control strobes. Runs the T3–T6 branch steps after fetch.

Parameters:
- OPC_BRANCH, 5'b10010, opcode value identifying a conditional branch (IR[31:27]).
- OPC_W, 5, opcode field width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to execute the instruction currently in ir, after fetch.
- ir  in  32  instruction register: [31:27] opcode, [26:23] Ra, [22:19] C2, [18:0] C offset.
- con  in  1  registered output of the CON flip-flop.
- con_in  out  1  load strobe to CON flip-flop.
- con_bits  out  2  condition select to CON flip-flop: latched C2[1:0] (00 zero, 01 nonzero, 10 ≥0, 11 <0).
- gra  out  1  select Ra field for register-file decode.
- r_out  out  1  drive selected register onto bus.
- pc_out  out  1  drive PC onto bus.
- y_in  out  1  load Y register.
- c_out  out  1  drive sign-extended C onto bus.
- alu_add  out  1  ALU operation = ADD.
- z_in  out  1  load Z register.
- zlow_out  out  1  drive Z low onto bus.
- pc_in  out  1  load PC from bus.
- taken  out  1  branch-taken flag, valid in S_LOAD and S_DONE.
- busy  out  1  high in every state except S_IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse: start received with a non-branch opcode.

Behaviour:
- Reset:
  - state = S_IDLE.
  - Latched C2 = 0 and taken = 0.
  - All strobes, done and err = 0.
  - Reset in any state aborts the sequence on the next edge. No strobe is asserted in the cycle after reset.
- Outputs are Moore, decoded from registered state. Exception: pc_in = con while in S_LOAD.
- States and transitions:
  - S_IDLE:
    - start=1 and ir[31:27]==OPC_BRANCH: latch ir[20:19] into con_bits register; go to S_RA.
    - start=1 and opcode is not a branch: err=1 next cycle (registered pulse); stay in S_IDLE.
    - start=0: hold.
  - S_RA (T3): gra=1, r_out=1, con_in=1, con_bits=latched value. Go to S_PC.
  - S_PC (T4): pc_out=1, y_in=1. Go to S_ADD.
  - S_ADD (T5): c_out=1, alu_add=1, z_in=1. Go to S_LOAD.
  - S_LOAD (T6): zlow_out=1; pc_in=con; taken register loads con. Go to S_DONE.
  - S_DONE: done=1, taken held. Go to S_IDLE.
- Latency: start edge to done is 5 cycles; pc_in, when asserted, is asserted in cycle 4.
- con is sampled only in S_LOAD. Its value in other states is ignored. CON FF has updated by then, one edge after S_RA.
- start while busy=1, including S_DONE: ignored, not queued, no err.
- con_bits is driven from the latched copy, so changes on ir after start do not affect the sequence.
- At most one strobe group is active per cycle. No bus driver overlap: r_out, pc_out, c_out and zlow_out are mutually exclusive.
- taken clears on entry to S_RA.

Test Plan:
- Reset with start=1 held: all outputs 0, busy=0 for the whole reset window; no err.
- ir=32'h9000_0023 (brzr, C2=0000), con=1 at S_LOAD:
  - con_in=1 with con_bits=00 in cycle 1.
  - pc_in=1 and taken=1 in cycle 4.
  - done in cycle 5; busy high in cycles 1–5.
- ir with C2=0011 (brmi), con=0: con_bits=11 in S_RA; pc_in=0, taken=0; zlow_out still pulses; done in cycle 5.
- start with opcode 5'b00011: err=1 for exactly one cycle; no strobes; state stays S_IDLE.
- Second start pulsed during S_ADD, and ir changed to C2=01 mid-sequence: ignored; con_bits stays the original value; exactly one done.
- reset asserted during S_PC: next cycle is S_IDLE with all strobes 0; a fresh start then completes normally in 5 cycles.
